// File: rtl/sound_mixer_pkg.sv
// Shared sound-subsystem definitions: mixer state encoding, mix width helpers
// and the NR50/NR51 field positions also used by the register block.
package sound_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUT
    } mix_state_t;

    localparam int VOL_W = 3;

    localparam int NR50_VOL_R_LSB = 0;
    localparam int NR50_VIN_R_BIT = 3;
    localparam int NR50_VOL_L_LSB = 4;
    localparam int NR50_VIN_L_BIT = 7;
    localparam int NR51_PAN_R_LSB = 0;
    localparam int NR51_PAN_L_LSB = 4;

    // Signed mode needs one extra bit because each term is re-centred around zero.
    function automatic int sum_w(input int num_ch, input int lvl_w, input int signed_mode);
        return lvl_w + $clog2(num_ch) + ((signed_mode != 0) ? 1 : 0);
    endfunction

    function automatic int scaled_w(input int num_ch, input int lvl_w, input int signed_mode);
        return sum_w(num_ch, lvl_w, signed_mode) + VOL_W;
    endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// Request/level/result bundle between the channel generators and the mixer.
interface sound_mixer_if #(
    parameter int NUM_CH = 4,
    parameter int LVL_W  = 4,
    parameter int OUT_W  = 20
);
    import sound_mixer_pkg::*;

    logic                      sample_req;
    logic                      master_en;
    logic [NUM_CH*LVL_W-1:0]   ch_level;
    logic [NUM_CH-1:0]         pan_l;
    logic [NUM_CH-1:0]         pan_r;
    logic [VOL_W-1:0]          vol_l;
    logic [VOL_W-1:0]          vol_r;
    logic [OUT_W-1:0]          left;
    logic [OUT_W-1:0]          right;
    logic                      sample_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output sample_req, master_en, ch_level, pan_l, pan_r, vol_l, vol_r,
        input  left, right, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_req, master_en, ch_level, pan_l, pan_r, vol_l, vol_r,
        output left, right, sample_valid, busy, overrun
    );

endinterface

// File: rtl/sound_mix_scale.sv
// Exact SUM_W x 3-bit volume multiply; gain is vol+1, so the result needs only 3 extra bits.
module sound_mix_scale
    import sound_mixer_pkg::*;
#(
    parameter int SUM_W       = 6,
    parameter int SIGNED_MODE = 0
) (
    input  logic [SUM_W-1:0]       acc,
    input  logic [VOL_W-1:0]       vol,
    output logic [SUM_W+VOL_W-1:0] scaled
);
    localparam int SCALED_W = SUM_W + VOL_W;

    logic [SCALED_W-1:0] acc_ext;
    logic [SCALED_W-1:0] gain;

    // Truncated products are sign-agnostic, so only the operand extension differs by mode.
    assign acc_ext = (SIGNED_MODE != 0) ? {{VOL_W{acc[SUM_W-1]}}, acc}
                                        : {{VOL_W{1'b0}}, acc};
    assign gain    = SCALED_W'(vol) + SCALED_W'(1);
    assign scaled  = acc_ext * gain;

endmodule

// File: rtl/sound_mixer.sv
// Time-multiplexed NUM_CH-channel mixer: one channel accumulated per clock,
// then per-side volume scaling and a registered, left-justified sample.
module sound_mixer
    import sound_mixer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int LVL_W       = 4,
    parameter int OUT_W       = 20,
    parameter int SIGNED_MODE = 0
) (
    input logic         clk,
    input logic         rst,
    sound_mixer_if.slave bus
);
    localparam int SUM_W    = sum_w(NUM_CH, LVL_W, SIGNED_MODE);
    localparam int SCALED_W = scaled_w(NUM_CH, LVL_W, SIGNED_MODE);
    localparam int PAD      = (SIGNED_MODE != 0) ? OUT_W - SCALED_W : OUT_W - 1 - SCALED_W;
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SUM_W-1:0]  BIAS = (SIGNED_MODE != 0) ? SUM_W'(1 << (LVL_W - 1)) : '0;
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_CH - 1);

    mix_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic [NUM_CH*LVL_W-1:0] snap_level;
    logic [NUM_CH-1:0]       snap_pan_l;
    logic [NUM_CH-1:0]       snap_pan_r;
    logic [VOL_W-1:0]        snap_vol_l;
    logic [VOL_W-1:0]        snap_vol_r;
    logic                    snap_en;
    logic [SUM_W-1:0]        acc_l;
    logic [SUM_W-1:0]        acc_r;
    logic [SCALED_W-1:0]     scaled_l;
    logic [SCALED_W-1:0]     scaled_r;
    logic [SCALED_W-1:0]     mul_l;
    logic [SCALED_W-1:0]     mul_r;
    logic [SUM_W-1:0]        term;
    logic [OUT_W-1:0]        left_q;
    logic [OUT_W-1:0]        right_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    // Signed mode re-centres each level; modulo-2^SUM_W subtraction gives the two's-complement term.
    always_comb begin
        term = SUM_W'(snap_level[idx*LVL_W +: LVL_W]) - BIAS;
    end

    sound_mix_scale #(.SUM_W(SUM_W), .SIGNED_MODE(SIGNED_MODE)) u_scale_l (
        .acc(acc_l), .vol(snap_vol_l), .scaled(mul_l)
    );

    sound_mix_scale #(.SUM_W(SUM_W), .SIGNED_MODE(SIGNED_MODE)) u_scale_r (
        .acc(acc_r), .vol(snap_vol_r), .scaled(mul_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            snap_level <= '0;
            snap_pan_l <= '0;
            snap_pan_r <= '0;
            snap_vol_l <= '0;
            snap_vol_r <= '0;
            snap_en    <= 1'b0;
            acc_l      <= '0;
            acc_r      <= '0;
            scaled_l   <= '0;
            scaled_r   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= bus.sample_req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.sample_req) begin
                        snap_level <= bus.ch_level;
                        snap_pan_l <= bus.pan_l;
                        snap_pan_r <= bus.pan_r;
                        snap_vol_l <= bus.vol_l;
                        snap_vol_r <= bus.vol_r;
                        snap_en    <= bus.master_en;
                        acc_l      <= '0;
                        acc_r      <= '0;
                        idx        <= '0;
                        busy_q     <= 1'b1;
                        state      <= ACCUM;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (snap_pan_l[idx]) acc_l <= acc_l + term;
                    if (snap_pan_r[idx]) acc_r <= acc_r + term;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST) state <= SCALE;
                end
                SCALE: begin
                    scaled_l <= mul_l;
                    scaled_r <= mul_r;
                    state    <= OUT;
                end
                OUT: begin
                    // Unsigned mode keeps a zero MSB so the sample never reads as negative downstream.
                    left_q  <= snap_en ? (OUT_W'(scaled_l) << PAD) : '0;
                    right_q <= snap_en ? (OUT_W'(scaled_r) << PAD) : '0;
                    valid_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.left         = left_q;
    assign bus.right        = right_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: unsigned and signed instances sharing one stimulus set.
module tb_sound_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_u;
    logic        req_s;
    logic        master_en;
    logic [15:0] ch_level;
    logic [3:0]  pan_l;
    logic [3:0]  pan_r;
    logic [2:0]  vol_l;
    logic [2:0]  vol_r;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int n;
    int valid_cnt;

    always #5 clk = ~clk;

    sound_mixer_if #(.NUM_CH(4), .LVL_W(4), .OUT_W(20)) bus ();
    sound_mixer_if #(.NUM_CH(4), .LVL_W(4), .OUT_W(20)) bus_s ();

    assign bus.sample_req   = req_u;
    assign bus.master_en    = master_en;
    assign bus.ch_level     = ch_level;
    assign bus.pan_l        = pan_l;
    assign bus.pan_r        = pan_r;
    assign bus.vol_l        = vol_l;
    assign bus.vol_r        = vol_r;
    assign bus_s.sample_req = req_s;
    assign bus_s.master_en  = master_en;
    assign bus_s.ch_level   = ch_level;
    assign bus_s.pan_l      = pan_l;
    assign bus_s.pan_r      = pan_r;
    assign bus_s.vol_l      = vol_l;
    assign bus_s.vol_r      = vol_r;

    sound_mixer #(.NUM_CH(4), .LVL_W(4), .OUT_W(20), .SIGNED_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    sound_mixer #(.NUM_CH(4), .LVL_W(4), .OUT_W(20), .SIGNED_MODE(1)) u_dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] lv, input logic [3:0] pl, input logic [3:0] pr,
                                  input logic [2:0] vl, input logic [2:0] vr, input logic en);
        ch_level  = lv;
        pan_l     = pl;
        pan_r     = pr;
        vol_l     = vl;
        vol_r     = vr;
        master_en = en;
    endtask

    task automatic pulse_req(input bit sgn);
        if (sgn) req_s = 1'b1;
        else     req_u = 1'b1;
        tick();
        req_s = 1'b0;
        req_u = 1'b0;
    endtask

    task automatic wait_valid(input bit sgn, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(sgn ? bus_s.sample_valid : bus.sample_valid) && cycles < 20);
    endtask

    initial begin
        rst   = 1'b1;
        req_u = 1'b0;
        req_s = 1'b0;
        apply_stimulus(16'h0000, 4'h0, 4'h0, 3'd0, 3'd0, 1'b0);
        repeat (3) tick();
        check_output("reset_left",    32'(bus.left), 32'h0);
        check_output("reset_right",   32'(bus.right), 32'h0);
        check_output("reset_valid",   32'(bus.sample_valid), 32'h0);
        check_output("reset_busy",    32'(bus.busy), 32'h0);
        check_output("reset_overrun", 32'(bus.overrun), 32'h0);
        check_output("reset_left_s",  32'(bus_s.left), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] full-scale mix");
        apply_stimulus(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b1);
        pulse_req(0);
        check_output("full_busy", 32'(bus.busy), 32'h1);
        wait_valid(0, n);
        check_output("full_latency", 32'(n), 32'd6);
        check_output("full_left",    32'(bus.left), 32'h78000);
        check_output("full_right",   32'(bus.right), 32'h78000);
        tick();
        check_output("full_valid_drop", 32'(bus.sample_valid), 32'h0);
        check_output("full_busy_drop",  32'(bus.busy), 32'h0);
        check_output("full_hold_left",  32'(bus.left), 32'h78000);
        check_output("full_no_overrun", 32'(bus.overrun), 32'h0);

        $display("[TB] panning with inputs changed after request");
        apply_stimulus(16'h0035, 4'b0001, 4'b0010, 3'd1, 3'd0, 1'b1);
        pulse_req(0);
        apply_stimulus(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b1);
        wait_valid(0, n);
        check_output("pan_latency", 32'(n), 32'd6);
        check_output("pan_left",    32'(bus.left), 32'h02800);
        check_output("pan_right",   32'(bus.right), 32'h00C00);

        $display("[TB] signed mode");
        apply_stimulus(16'h0000, 4'hF, 4'hF, 3'd0, 3'd0, 1'b1);
        pulse_req(1);
        wait_valid(1, n);
        check_output("signed_latency", 32'(n), 32'd6);
        check_output("signed_min_left",  32'(bus_s.left), 32'hF8000);
        check_output("signed_min_right", 32'(bus_s.right), 32'hF8000);
        apply_stimulus(16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 1'b1);
        pulse_req(1);
        wait_valid(1, n);
        check_output("signed_max_left",  32'(bus_s.left), 32'h38000);
        check_output("signed_max_right", 32'(bus_s.right), 32'h00000);

        $display("[TB] overrun");
        apply_stimulus(16'h1111, 4'hF, 4'hF, 3'd3, 3'd0, 1'b1);
        pulse_req(0);
        apply_stimulus(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b1);
        tick();
        req_u = 1'b1;
        tick();
        req_u = 1'b0;
        check_output("overrun_pulse", 32'(bus.overrun), 32'h1);
        tick();
        check_output("overrun_single", 32'(bus.overrun), 32'h0);
        wait_valid(0, n);
        check_output("overrun_latency", 32'(n), 32'd3);
        check_output("overrun_left",    32'(bus.left), 32'h04000);
        check_output("overrun_right",   32'(bus.right), 32'h01000);
        valid_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.sample_valid) valid_cnt++;
        end
        check_output("overrun_one_valid", 32'(valid_cnt), 32'd0);

        $display("[TB] reset during accumulate");
        pulse_req(0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_output("midrst_left",  32'(bus.left), 32'h0);
        check_output("midrst_right", 32'(bus.right), 32'h0);
        check_output("midrst_busy",  32'(bus.busy), 32'h0);
        check_output("midrst_valid", 32'(bus.sample_valid), 32'h0);
        tick();
        rst = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sample_valid) valid_cnt++;
        end
        check_output("midrst_no_valid", 32'(valid_cnt), 32'd0);
        apply_stimulus(16'h0035, 4'b0001, 4'b0010, 3'd1, 3'd0, 1'b1);
        pulse_req(0);
        wait_valid(0, n);
        check_output("postrst_latency", 32'(n), 32'd6);
        check_output("postrst_left",    32'(bus.left), 32'h02800);
        check_output("postrst_right",   32'(bus.right), 32'h00C00);

        $display("[TB] master disable");
        apply_stimulus(16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1'b0);
        pulse_req(0);
        wait_valid(0, n);
        check_output("muted_latency", 32'(n), 32'd6);
        check_output("muted_left",    32'(bus.left), 32'h0);
        check_output("muted_right",   32'(bus.right), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
